// File: rtl/multi_port_ram.sv
// Synchronous memory with a registered instruction-fetch port, a byte-lane data port,
// store-to-fetch write-first forwarding, out-of-range detection and a post-reset clear sweep.
module multi_port_ram #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = 32,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     pc_addr,
    output logic [DATA_W-1:0]     if_data,
    output logic                  if_valid,
    output logic                  if_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_valid,
    output logic                  d_err,
    output logic                  busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               clear_we;

    logic [DATA_W-1:0]  mem [DEPTH];

    // Full word indices are kept so that any high address bit flags out-of-range.
    logic [ADDR_W-1:0]  if_word, d_word;
    logic [IDX_W-1:0]   if_idx, d_idx;
    logic               if_in_range, d_in_range;

    assign if_word     = pc_addr >> OFF_W;
    assign d_word      = d_addr >> OFF_W;
    assign if_idx      = if_word[IDX_W-1:0];
    assign d_idx       = d_word[IDX_W-1:0];
    assign if_in_range = (if_word < ADDR_W'(DEPTH));
    assign d_in_range  = (d_word < ADDR_W'(DEPTH));

    logic ready, fetch_go, load_go, store_go, store_hit;

    assign ready     = (state_q == READY);
    assign fetch_go  = ready && if_req;
    assign load_go   = ready && d_req && !d_we;
    assign store_go  = ready && d_req && d_we;
    assign store_hit = store_go && d_in_range;
    assign busy      = INIT_CLEAR && (state_q == CLEAR);

    // Word as it will read after this edge's store; feeds write-first forwarding.
    logic [DATA_W-1:0] merged;

    // NOTE: every variable written in always_comb gets a default first, or a latch is inferred.
    always_comb begin
        merged = mem[d_idx];
        for (int i = 0; i < BE_W; i++) begin
            if (d_be[i]) begin
                merged[8*i +: 8] = d_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clear_we = 1'b0;
        case (state_q)
            CLEAR: begin
                if (INIT_CLEAR) begin
                    clear_we = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_d = READY;
                        cnt_d   = '0;
                    end
                end else begin
                    state_d = READY;
                end
            end
            READY:   state_d = READY;
            default: state_d = CLEAR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: the array has no reset branch; the clear sweep zeroes it so it still maps to RAM.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clear_we) begin
                mem[cnt_q] <= '0;
            end else if (store_hit) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (d_be[i]) begin
                        mem[d_idx][8*i +: 8] <= d_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_data  <= '0;
            if_valid <= 1'b0;
            if_err   <= 1'b0;
            d_rdata  <= '0;
            d_valid  <= 1'b0;
            d_err    <= 1'b0;
        end else begin
            if_valid <= fetch_go;
            if_err   <= fetch_go && !if_in_range;
            d_valid  <= load_go || store_go;
            d_err    <= (load_go || store_go) && !d_in_range;

            if (fetch_go) begin
                if (!if_in_range) begin
                    if_data <= '0;
                end else if (store_hit && (d_idx == if_idx)) begin
                    if_data <= merged;
                end else begin
                    if_data <= mem[if_idx];
                end
            end

            // Stores leave d_rdata untouched.
            if (load_go) begin
                d_rdata <= d_in_range ? mem[d_idx] : '0;
            end
        end
    end

endmodule

// File: tb/tb_multi_port_ram.sv
// Directed plus randomized bench for multi_port_ram, checked against a word-array model
// that applies each edge's store before its fetch and tracks the clear sweep as a countdown.
module tb_multi_port_ram;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] pc_addr = '0;
    logic [DATA_W-1:0] if_data;
    logic              if_valid, if_err;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [3:0]        d_be = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid, d_err, busy;

    multi_port_ram #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT_CLEAR(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .pc_addr(pc_addr), .if_data(if_data),
        .if_valid(if_valid), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] exp_if = '0;
    logic [31:0] exp_rd = '0;
    int          sweep_left = DEPTH;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock with the given requests; the model decides what each port must show.
    task automatic cyc(input string tag, input logic fr, input logic [31:0] pc,
                       input logic dr, input logic we, input logic [31:0] da,
                       input logic [3:0] be, input logic [31:0] wd);
        bit serve;
        int fi, di;
        logic exp_iv, exp_ie, exp_dv, exp_de;
        if_req = fr; pc_addr = pc; d_req = dr; d_we = we; d_addr = da; d_be = be; d_wdata = wd;
        serve  = (sweep_left == 0);
        exp_iv = 1'b0; exp_ie = 1'b0; exp_dv = 1'b0; exp_de = 1'b0;
        fi = int'(pc >> 2);
        di = int'(da >> 2);
        if (serve && dr) begin
            exp_dv = 1'b1;
            exp_de = (di >= DEPTH);
            if (we) begin
                if (di < DEPTH)
                    for (int l = 0; l < 4; l++)
                        if (be[l]) model[di][8*l +: 8] = wd[8*l +: 8];
            end else begin
                exp_rd = (di < DEPTH) ? model[di] : 32'h0;
            end
        end
        if (serve && fr) begin
            exp_iv = 1'b1;
            exp_ie = (fi >= DEPTH);
            exp_if = (fi < DEPTH) ? model[fi] : 32'h0;
        end
        tick();
        if (sweep_left > 0) begin
            sweep_left--;
            if (sweep_left == 0)
                for (int k = 0; k < DEPTH; k++) model[k] = '0;
        end
        check({tag, ".if_valid"}, 32'(if_valid), 32'(exp_iv));
        check({tag, ".if_err"},   32'(if_err),   32'(exp_ie));
        check({tag, ".if_data"},  if_data,       exp_if);
        check({tag, ".d_valid"},  32'(d_valid),  32'(exp_dv));
        check({tag, ".d_err"},    32'(d_err),    32'(exp_de));
        check({tag, ".d_rdata"},  d_rdata,       exp_rd);
        check({tag, ".busy"},     32'(busy),     32'(sweep_left > 0));
    endtask

    // Hold reset for n edges with requests asserted, then release.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_wdata = 32'hA5A5A5A5;
        for (int i = 0; i < n; i++) tick();
        check("rst.if_valid", 32'(if_valid), 32'h0);
        check("rst.d_valid",  32'(d_valid),  32'h0);
        check("rst.if_err",   32'(if_err),   32'h0);
        check("rst.d_err",    32'(d_err),    32'h0);
        check("rst.if_data",  if_data,       32'h0);
        check("rst.d_rdata",  d_rdata,       32'h0);
        check("rst.busy",     32'(busy),     32'h1);
        rst_n = 1'b1;
        if_req = 1'b0; d_req = 1'b0;
        sweep_left = DEPTH;
        exp_if = '0;
        exp_rd = '0;
    endtask

    // Counts busy cycles from reset release; optionally hammers both ports meanwhile.
    task automatic sweep_check(input bit reqs);
        int n;
        n = busy ? 1 : 0;
        for (int i = 0; i <= DEPTH; i++) begin
            cyc("sweep", reqs && (i < DEPTH), 32'($urandom_range(0, 7) * 4),
                reqs && (i < DEPTH), 1'b1, 32'($urandom_range(0, 7) * 4),
                4'hF, $urandom);
            if (busy) n++;
        end
        check("busy_cycles", 32'(n), 32'(DEPTH));
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) model[k] = 'x;

        // Clear sweep, then every word reads zero.
        do_reset(2);
        sweep_check(1'b0);
        for (int a = 0; a < DEPTH; a++)
            cyc("clr_fetch", 1'b1, 32'(a * 4), 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

        // Full-word store, then fetch.
        cyc("st_full", 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        cyc("fe_full", 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check("fe_full.const", if_data, 32'hDEADBEEF);

        // Single byte lane, then load with ignored offset bits.
        cyc("st_lane", 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 4'b0010, 32'h0000AA00);
        cyc("ld_lane", 1'b0, 32'h0, 1'b1, 1'b0, 32'h13, 4'h0, 32'h0);
        check("ld_lane.const", d_rdata, 32'hDEADAAEF);

        // Zero-lane store is acknowledged and changes nothing.
        cyc("st_nobe", 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 4'h0, 32'h11111111);
        cyc("ld_nobe", 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);

        // Same-edge store and fetch: write-first.
        cyc("fwd", 1'b1, 32'h20, 1'b1, 1'b1, 32'h20, 4'hF, 32'h12345678);
        check("fwd.const", if_data, 32'h12345678);
        cyc("fwd_lane", 1'b1, 32'h22, 1'b1, 1'b1, 32'h20, 4'b1000, 32'hCC000000);

        // Out of range store, fetch, load.
        cyc("oor_st", 1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 4'hF, 32'hFFFFFFFF);
        for (int a = 0; a < DEPTH; a++)
            cyc("oor_scan", 1'b0, 32'h0, 1'b1, 1'b0, 32'(a * 4), 4'h0, 32'h0);
        cyc("oor_fe", 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check("oor_fe.const", if_data, 32'h0);
        cyc("oor_ld", 1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0000, 4'h0, 32'h0);

        // Randomized back-to-back traffic on both ports.
        for (int i = 0; i < 300; i++)
            cyc("rand", 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 39) * 4 + $urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 39) * 4 + $urandom_range(0, 3)),
                4'($urandom_range(0, 15)), $urandom);

        // Reset while the sweep is at word 10, requests held high throughout.
        do_reset(1);
        for (int i = 0; i < 10; i++)
            cyc("mid", 1'b1, 32'h0, 1'b1, 1'b1, 32'(i * 4), 4'hF, $urandom);
        do_reset(1);
        sweep_check(1'b1);
        for (int a = 0; a < DEPTH; a++)
            cyc("post_scan", 1'b1, 32'(a * 4), 1'b1, 1'b0, 32'((DEPTH - 1 - a) * 4),
                4'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
